// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode encodings, board clock constant and sizing helpers
// for the multi-channel clock/tick divider.
package clk_div_pkg;

    localparam bit MODE_TOGGLE = 1'b0;
    localparam bit MODE_PULSE  = 1'b1;
    localparam int CLK_HZ      = 50000000;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Divisor giving a toggle-mode output of f Hz from the board clock
    function automatic int DIV_FOR_HZ(input int f);
        return CLK_HZ / (2 * f);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; new settings wait in a shadow and take
// effect on a period boundary so no output pulse is ever shortened.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int DEF_DIV  = 25000000,
    parameter bit DEF_MODE = MODE_TOGGLE,
    parameter bit DEF_EN   = 1'b1
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             mode_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic             mode;
        logic             en;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{div: CNT_W'(DEF_DIV), mode: DEF_MODE, en: DEF_EN};

    cfg_t             cur_q, cur_d, sh_q, sh_d, wr_cfg;
    logic [CNT_W-1:0] cnt_q, cnt_d, eff;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, tc, apply;

    always_comb begin
        wr_cfg = '{div: div_i, mode: mode_i, en: en_i};
        eff    = (cur_q.div < CNT_W'(2)) ? CNT_W'(1) : cur_q.div;
        tc     = cur_q.en && (cnt_q == eff - CNT_W'(1));
        apply  = !restart_i && pend_q && (!cur_q.en || tc);
        // a write landing together with restart skips the shadow entirely
        cur_d  = (restart_i && wr_i) ? wr_cfg :
                 ((restart_i || apply) && pend_q) ? sh_q : cur_q;
        sh_d   = wr_i ? wr_cfg : sh_q;
        pend_d = !restart_i && (wr_i || (pend_q && !apply));
        cnt_d  = (restart_i || apply || tc || !cur_q.en) ? '0 : cnt_q + CNT_W'(1);
        tick_d = !restart_i && cur_d.en && tc;
        clk_d  = (restart_i || !cur_d.en) ? 1'b0 :
                 (cur_d.mode == MODE_PULSE) ? tick_d :
                 apply ? (cur_q.mode == MODE_TOGGLE && clk_q) : (clk_q ^ tc);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= DEF_CFG;
            sh_q   <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH programmable clock/tick channels with config decode,
// write acknowledge/error strobes and a global restart.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  N_CH     = 4,
    parameter int  CNT_W    = 26,
    parameter int  DEF_DIV  = 25000000,
    parameter bit  DEF_MODE = MODE_TOGGLE,
    parameter bit  DEF_EN   = 1'b1,
    localparam int CH_W     = ch_w(N_CH)
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    output logic             cfg_ack,
    output logic             cfg_err,
    input  logic             sync_restart,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    logic valid, ack_q, err_q;

    assign valid = cfg_wr && (32'(cfg_ch) < N_CH);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= valid;
            err_q <= cfg_wr && !valid;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE),
            .DEF_EN   (DEF_EN)
        ) u_chan (
            .clk_50M   (clk_50M),
            .rst_n     (rst_n),
            .restart_i (sync_restart),
            .wr_i      (valid && (32'(cfg_ch) == i)),
            .div_i     (cfg_div),
            .mode_i    (cfg_mode),
            .en_i      (cfg_en),
            .clk_o     (clk_out[i]),
            .tick_o    (tick[i]),
            .pending_o (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: random and directed stimulus checked every cycle against a
// period-arithmetic model of each channel, plus hand-computed anchor values.
module tb_clk_div_multi;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int DD = 4;

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         cfg_wr = 1'b0, cfg_mode = 1'b0, cfg_en = 1'b0, sync_restart = 1'b0;
    logic [2:0]   cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ack, cfg_err;
    logic [N-1:0] clk_out, tick, pending;

    int checks = 0, errors = 0, cyc = 0;

    // Model: active config, shadow, and the cycle at which the current period grid started
    int           m_div[N], sh_div[N], m_s[N];
    bit           m_mode[N], m_en[N], sh_mode[N], sh_en[N], m_pend[N], m_lvl[N];
    logic [N-1:0] e_clk, e_tick;
    logic         e_ack, e_err;

    always #10 clk = ~clk;

    clk_div_multi #(
        .N_CH(N), .CNT_W(W), .DEF_DIV(DD), .DEF_MODE(1'b0), .DEF_EN(1'b1)
    ) dut (
        .clk_50M(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .sync_restart(sync_restart),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_div[i] = DD; m_mode[i] = 1'b0; m_en[i] = 1'b1;
            sh_div[i] = 0; sh_mode[i] = 1'b0; sh_en[i] = 1'b0;
            m_pend[i] = 1'b0; m_s[i] = 0; m_lvl[i] = 1'b0;
        end
        e_clk = '0; e_tick = '0; e_ack = 1'b0; e_err = 1'b0;
        cyc = 0;
    endtask

    task automatic model_update();
        bit valid;
        valid = cfg_wr && (cfg_ch < N);
        e_ack = valid;
        e_err = cfg_wr && !valid;
        for (int i = 0; i < N; i++) begin
            bit w, was_en, tc, ap, old_tog, old_clk, new_phase;
            int eff;
            w       = valid && (int'(cfg_ch) == i);
            eff     = (m_div[i] < 2) ? 1 : m_div[i];
            was_en  = m_en[i];
            tc      = was_en && ((cyc - m_s[i]) % eff == eff - 1);
            ap      = !sync_restart && m_pend[i] && (!was_en || tc);
            old_tog = !m_mode[i];
            old_clk = e_clk[i];
            if (sync_restart && w) begin
                m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_en[i] = cfg_en;
            end else if ((sync_restart || ap) && m_pend[i]) begin
                m_div[i] = sh_div[i]; m_mode[i] = sh_mode[i]; m_en[i] = sh_en[i];
            end
            new_phase = sync_restart || ap || !was_en;
            if (new_phase) m_s[i] = cyc + 1;
            if (w) begin
                sh_div[i] = int'(cfg_div); sh_mode[i] = cfg_mode; sh_en[i] = cfg_en;
            end
            m_pend[i] = !sync_restart && (w || (m_pend[i] && !ap));
            e_tick[i] = !sync_restart && m_en[i] && tc;
            if (sync_restart || !m_en[i]) e_clk[i] = 1'b0;
            else if (m_mode[i]) e_clk[i] = e_tick[i];
            else if (ap) e_clk[i] = old_tog && old_clk;
            else e_clk[i] = m_lvl[i] ^ ((((cyc + 1 - m_s[i]) / eff) % 2) == 1);
            if (new_phase) m_lvl[i] = e_clk[i];
        end
    endtask

    task automatic step();
        logic [N-1:0] pv;
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        for (int i = 0; i < N; i++) pv[i] = m_pend[i];
        chk("clk_out", clk_out, e_clk);
        chk("tick", tick, e_tick);
        chk("pending", pending, pv);
        chk("cfg_ack", cfg_ack, e_ack);
        chk("cfg_err", cfg_err, e_err);
    endtask

    task automatic write_cfg(input int ch, input int d, input bit m, input bit e, input bit rs = 1'b0);
        cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = W'(d); cfg_mode = m; cfg_en = e;
        sync_restart = rs;
        step();
        cfg_wr = 1'b0; sync_restart = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ack_err", {cfg_ack, cfg_err}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] tk, ck;
        logic [3:0] v;
        int n, first[4];

        do_reset();

        // Default divisor 4 in toggle mode: tick on edges 4 and 8, clock high for edges 4..7
        for (int k = 0; k < 8; k++) begin
            step();
            tk[k] = tick[0];
            ck[k] = clk_out[0];
        end
        chk("rst_tick0_pattern", tk, 8'b1000_1000);
        chk("rst_clk0_pattern", ck, 8'b0111_1000);
        repeat (32) step();
        chk("idle_pending", pending, 0);

        // ch1 to divisor 3, pulse mode, while running at the default
        write_cfg(1, 3, 1'b1, 1'b1);
        chk("ch1_ack", cfg_ack, 1);
        chk("ch1_pend_set", pending[1], 1);
        n = 0;
        while (pending[1] && n < 10) begin step(); n++; end
        chk("ch1_applied", pending[1], 0);
        chk("ch1_tick_at_apply", tick[1], 1);
        chk("ch1_clk_at_apply", clk_out[1], 1);
        n = 0;
        do begin step(); n++; end while (!tick[1] && n < 10);
        chk("ch1_period", n, 3);

        // ch2 to divisor 0 then 1: both mean divide-by-one
        write_cfg(2, 0, 1'b0, 1'b1);
        n = 0;
        while (pending[2] && n < 10) begin step(); n++; end
        for (int k = 0; k < 4; k++) begin
            step();
            v[k] = clk_out[2];
            chk("ch2_div0_tick", tick[2], 1);
        end
        chk("ch2_toggle_each_cycle", (v == 4'b0101) || (v == 4'b1010), 1);
        write_cfg(2, 1, 1'b0, 1'b1);
        repeat (4) step();
        chk("ch2_div1_tick", tick[2], 1);

        // Invalid channel
        write_cfg(5, 7, 1'b1, 1'b0);
        chk("bad_ch_err", cfg_err, 1);
        chk("bad_ch_ack", cfg_ack, 0);

        // Restart realignment with a same-cycle write
        write_cfg(0, 4, 1'b0, 1'b1);
        write_cfg(1, 3, 1'b0, 1'b1);
        write_cfg(2, 5, 1'b0, 1'b1);
        write_cfg(3, 6, 1'b0, 1'b1);
        repeat (20) step();
        chk("pre_restart_pending", pending, 0);
        write_cfg(3, 2, 1'b0, 1'b1, 1'b1);
        chk("restart_clk_low", clk_out[3:0], 0);
        chk("restart_tick_low", tick[3:0], 0);
        chk("restart_ack", cfg_ack, 1);
        chk("restart_no_pend", pending[3], 0);
        first = '{0, 0, 0, 0};
        for (int k = 1; k <= 10; k++) begin
            step();
            for (int c = 0; c < 4; c++) if (first[c] == 0 && tick[c]) first[c] = k;
        end
        chk("first_tick0", first[0], 4);
        chk("first_tick1", first[1], 3);
        chk("first_tick2", first[2], 5);
        chk("first_tick3", first[3], 2);

        // Reset mid-period while ch1 has a pending shadow
        write_cfg(1, 9, 1'b0, 1'b1);
        chk("pre_rst_pend1", pending[1], 1);
        step();
        do_reset();
        n = 0;
        do begin step(); n++; end while (!clk_out[0] && n < 10);
        chk("post_rst_first_toggle", n, DD);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (k == 700) do_reset();
            if (r < 10)
                write_cfg($urandom_range(0, 7), $urandom_range(0, 9), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 4) != 0);
            else if (r < 12)
                write_cfg($urandom_range(0, 7), $urandom_range(0, 9), 1'($urandom_range(0, 1)),
                          1'b1, 1'b1);
            else if (r < 14) begin
                sync_restart = 1'b1;
                step();
                sync_restart = 1'b0;
            end else
                step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
